// File: rtl/sight_test_ctrl_if.sv
// Key inputs and display/chart outputs of the acuity test controller.
// Master drives the raw keys; slave is the controller.
interface sight_test_ctrl_if;
    logic       key_start;
    logic       key_ok;
    logic       key_ng;
    logic [7:0] bcd;
    logic       x_signal;
    logic [1:0] e_dir;
    logic       busy;
    logic       done;

    modport master (
        output key_start, key_ok, key_ng,
        input  bcd, x_signal, e_dir, busy, done
    );

    modport slave (
        input  key_start, key_ok, key_ng,
        output bcd, x_signal, e_dir, busy, done
    );
endinterface

// File: rtl/sight_test_ctrl.sv
// Visual-acuity test controller: key debounce, level/trial scoring,
// registered display drive and LFSR optotype direction.
module sight_test_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int TRIALS     = 4,
    parameter int PASS_NEED  = 3,
    parameter int MAX_LEVEL  = 15
) (
    input logic clk,
    input logic rst_n,
    sight_test_ctrl_if.slave bus
);
    localparam logic [23:0] DEB_M1 = 24'(DEB_CYCLES - 1);
    localparam logic [3:0]  TR     = 4'(TRIALS);
    localparam logic [3:0]  PN     = 4'(PASS_NEED);
    localparam logic [4:0]  ML     = 5'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

    logic [2:0]  w_raw;
    logic [2:0]  r_s1, r_s2, r_deb, r_debq, r_pls;
    logic [23:0] r_cnt [3];
    logic [15:0] r_lfsr;

    state_t      r_state, w_state_n;
    logic [4:0]  r_level, w_level_n;
    logic [3:0]  r_trial, w_trial_n;
    logic [3:0]  r_corr, w_corr_n;
    logic [4:0]  r_result, w_result_n;
    logic        r_flow, w_flow_n;
    logic        w_load_dir;

    logic [7:0]  r_bcd, w_bcd_n;
    logic        r_x, r_busy, r_done;
    logic [1:0]  r_edir;

    logic        w_start, w_ok, w_ng, w_ans;
    logic [3:0]  w_tri_inc, w_cor_inc;

    // index 0 = start, 1 = ok, 2 = ng
    assign w_raw     = {bus.key_ng, bus.key_ok, bus.key_start};
    assign w_start   = r_pls[0];
    assign w_ok      = r_pls[1];
    assign w_ng      = r_pls[2];
    assign w_ans     = w_ok ^ w_ng;
    assign w_tri_inc = r_trial + 4'd1;
    assign w_cor_inc = r_corr + {3'd0, w_ok};

    function automatic logic [7:0] to_bcd(input logic [4:0] l);
        if (l >= 5'd10)
            return {4'(l - 5'd10), 4'd1};
        else
            return {l[3:0], 4'd0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_deb  <= '0;
            r_debq <= '0;
            r_pls  <= '0;
            for (int i = 0; i < 3; i++)
                r_cnt[i] <= '0;
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_debq <= r_deb;
            r_pls  <= r_deb & ~r_debq;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_M1) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[14:0],
                       r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    always_comb begin
        w_state_n  = r_state;
        w_level_n  = r_level;
        w_trial_n  = r_trial;
        w_corr_n   = r_corr;
        w_result_n = r_result;
        w_flow_n   = r_flow;
        w_load_dir = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_state_n  = TEST;
                    w_level_n  = 5'd1;
                    w_trial_n  = '0;
                    w_corr_n   = '0;
                    w_flow_n   = 1'b0;
                    w_load_dir = 1'b1;
                end
            end
            TEST: begin
                if (w_start) begin
                    w_level_n  = 5'd1;
                    w_trial_n  = '0;
                    w_corr_n   = '0;
                    w_load_dir = 1'b1;
                end else if (w_ans) begin
                    w_load_dir = 1'b1;
                    if (w_tri_inc == TR) begin
                        w_trial_n = '0;
                        w_corr_n  = '0;
                        if (w_cor_inc >= PN) begin
                            if (r_level < ML) begin
                                w_level_n = r_level + 5'd1;
                            end else begin
                                w_state_n  = DONE;
                                w_result_n = r_level;
                            end
                        end else if (r_level > 5'd1) begin
                            w_state_n  = DONE;
                            w_result_n = r_level - 5'd1;
                        end else begin
                            w_state_n  = DONE;
                            w_result_n = 5'd1;
                            w_flow_n   = 1'b1;
                        end
                    end else begin
                        w_trial_n = w_tri_inc;
                        w_corr_n  = w_cor_inc;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they change with it.
    always_comb begin
        w_bcd_n = 8'hFF;
        if (w_state_n == TEST)
            w_bcd_n = to_bcd(w_level_n);
        else if (w_state_n == DONE)
            w_bcd_n = to_bcd(w_result_n);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state  <= IDLE;
            r_level  <= '0;
            r_trial  <= '0;
            r_corr   <= '0;
            r_result <= '0;
            r_flow   <= 1'b0;
            r_bcd    <= 8'hFF;
            r_x      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_edir   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_level  <= w_level_n;
            r_trial  <= w_trial_n;
            r_corr   <= w_corr_n;
            r_result <= w_result_n;
            r_flow   <= w_flow_n;
            r_bcd    <= w_bcd_n;
            r_x      <= (w_state_n == DONE) & w_flow_n;
            r_busy   <= (w_state_n == TEST);
            r_done   <= (w_state_n == DONE);
            if (w_load_dir)
                r_edir <= r_lfsr[1:0];
        end
    end

    assign bus.bcd      = r_bcd;
    assign bus.x_signal = r_x;
    assign bus.e_dir    = r_edir;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_sight_test_ctrl.sv
// Directed bench for sight_test_ctrl with short debounce.
// Expected values are hand-derived constants.
module tb_sight_test_ctrl;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] seen = '0;
    int   n_dir = 0;
    int   t_samp = 0;

    sight_test_ctrl_if bus();

    sight_test_ctrl #(
        .DEB_CYCLES(DEB),
        .TRIALS(4),
        .PASS_NEED(3),
        .MAX_LEVEL(15)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lvl_bcd(input int l);
        logic [3:0] t;
        if (l >= 10) begin
            t = 4'(l - 10);
            return {t, 4'd1};
        end
        t = 4'(l);
        return {t, 4'd0};
    endfunction

    // k: 0 start, 1 ok, 2 ng, 3 ok+ng together
    task automatic press(input int k);
        @(posedge clk); #1;
        bus.key_start = (k == 0);
        bus.key_ok    = (k == 1 || k == 3);
        bus.key_ng    = (k == 2 || k == 3);
        repeat (10) @(posedge clk);
        #1;
        bus.key_start = 1'b0;
        bus.key_ok    = 1'b0;
        bus.key_ng    = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        if (t_samp > 0) begin
            seen[bus.e_dir] = 1'b1;
            t_samp--;
        end
    endtask

    task automatic answers(input int a, input int b,
                           input int c, input int d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    initial begin
        bus.key_start = 1'b0;
        bus.key_ok    = 1'b0;
        bus.key_ng    = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("rst_bcd", bus.bcd, 8'hFF);
        chk("rst_x", bus.x_signal, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_edir", bus.e_dir, 0);

        // bouncing start, then a clean settle timed to the edge
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus.key_start = 1'b1;
            repeat (2) @(posedge clk);
            #1 bus.key_start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        bus.key_start = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        @(negedge clk);
        chk("start_early", bus.busy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("start_busy", bus.busy, 1);
        chk("start_bcd", bus.bcd, 8'h10);
        repeat (3) @(posedge clk);
        #1 bus.key_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bounce_lvl", bus.bcd, 8'h10);

        // pass every level up to the top
        t_samp = 8;
        for (int l = 1; l < 15; l++) begin
            answers(1, 1, 2, 1);
            chk($sformatf("lvl%0d", l + 1), bus.bcd, lvl_bcd(l + 1));
        end
        for (int i = 0; i < 4; i++)
            n_dir += int'(seen[i]);
        chk("edir_distinct", 32'(n_dir >= 3), 1);
        answers(1, 1, 2, 1);
        chk("top_done", bus.done, 1);
        chk("top_busy", bus.busy, 0);
        chk("top_bcd", bus.bcd, 8'h51);
        chk("top_x", bus.x_signal, 0);
        press(1);
        press(2);
        chk("done_ign", bus.bcd, 8'h51);
        chk("done_ign_d", bus.done, 1);

        // fail at level 7 -> result 0.6
        press(0);
        chk("re_busy", bus.busy, 1);
        chk("re_bcd", bus.bcd, 8'h10);
        for (int l = 1; l <= 6; l++)
            answers(1, 1, 2, 1);
        chk("l7_bcd", bus.bcd, 8'h70);
        answers(2, 2, 1, 1);
        chk("f7_done", bus.done, 1);
        chk("f7_bcd", bus.bcd, 8'h60);
        chk("f7_x", bus.x_signal, 0);

        // fail at level 1 -> minus sign
        press(0);
        answers(1, 2, 2, 2);
        chk("f1_done", bus.done, 1);
        chk("f1_bcd", bus.bcd, 8'h10);
        chk("f1_x", bus.x_signal, 1);
        press(0);
        chk("f1r_busy", bus.busy, 1);
        chk("f1r_x", bus.x_signal, 0);
        chk("f1r_bcd", bus.bcd, 8'h10);

        // coincident ok+ng must not count as a trial
        press(3);
        press(1);
        press(1);
        press(2);
        chk("both_hold", bus.bcd, 8'h10);
        chk("both_busy", bus.busy, 1);
        press(1);
        chk("both_adv", bus.bcd, 8'h20);

        // start mid-level restarts at 0.1
        press(1);
        press(0);
        chk("mid_start", bus.bcd, 8'h10);
        for (int l = 1; l <= 4; l++)
            answers(1, 1, 2, 1);
        chk("l5_bcd", bus.bcd, 8'h50);
        press(1);

        // reset in the middle of level 5
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_bcd", bus.bcd, 8'hFF);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
